// File: rtl/qspi_arb.sv
// rtl/qspi_arb.sv - round-robin arbiter and sequencer sharing one qspi line-transfer engine
// among three requesters, with a per-transfer watchdog.
module qspi_arb #(
  parameter int PA          = 24,
  parameter int LINE_LENGTH = 4,
  parameter int TIMEOUT     = 255,
  localparam int TW = PA - $clog2(LINE_LENGTH),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [2:0]    req_i,
  input  logic [2:0]    wr_i,
  input  logic [1:0]    mem0_i,
  input  logic [1:0]    mem1_i,
  input  logic [1:0]    mem2_i,
  input  logic [TW-1:0] tag0_i,
  input  logic [TW-1:0] tag1_i,
  input  logic [TW-1:0] tag2_i,
  output logic [2:0]    gnt_o,
  output logic [2:0]    done_o,
  output logic          err_o,
  output logic          q_req_o,
  output logic          q_write_o,
  output logic          q_i_d_o,
  output logic [1:0]    q_mem_o,
  output logic [TW-1:0] q_paddr_o,
  input  logic          q_done_i
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [2:0]    done_q, done_d;
  logic          err_q, err_d;
  logic          q_req_q, q_req_d;
  logic          q_write_q, q_write_d;
  logic          q_i_d_q, q_i_d_d;
  logic [1:0]    q_mem_q, q_mem_d;
  logic [TW-1:0] q_paddr_q, q_paddr_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]    c1, c2, win;
  logic [1:0]    win_mem;
  logic [TW-1:0] win_tag;

  function automatic logic [1:0] rr_next(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Search order is last+1, last+2, then last itself, so the previous winner goes to the back.
  always_comb begin
    c1 = rr_next(last_q);
    c2 = rr_next(c1);
    if (req_i[c1])      win = c1;
    else if (req_i[c2]) win = c2;
    else                win = last_q;
    case (win)
      2'd0:    begin win_mem = mem0_i; win_tag = tag0_i; end
      2'd1:    begin win_mem = mem1_i; win_tag = tag1_i; end
      default: begin win_mem = mem2_i; win_tag = tag2_i; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = 3'b000;
    err_d     = 1'b0;
    q_req_d   = q_req_q;
    q_write_d = q_write_q;
    q_i_d_d   = q_i_d_q;
    q_mem_d   = q_mem_q;
    q_paddr_d = q_paddr_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_i != 3'b000) begin
          gnt_d     = 3'b001 << win;
          q_write_d = wr_i[win];
          q_mem_d   = win_mem;
          q_paddr_d = win_tag;
          q_i_d_d   = (win == 2'd0);
          q_req_d   = 1'b1;
          last_d    = win;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // A completion in the same cycle as the watchdog expiry is a normal finish.
        if (q_done_i || cnt_q == CW'(TIMEOUT)) begin
          done_d  = gnt_q;
          err_d   = ~q_done_i;
          q_req_d = 1'b0;
          gnt_d   = 3'b000;
          q_i_d_d = 1'b0;
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gnt_q     <= 3'b000;
      done_q    <= 3'b000;
      err_q     <= 1'b0;
      q_req_q   <= 1'b0;
      q_write_q <= 1'b0;
      q_i_d_q   <= 1'b0;
      q_mem_q   <= 2'd0;
      q_paddr_q <= '0;
      last_q    <= 2'd2;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      q_req_q   <= q_req_d;
      q_write_q <= q_write_d;
      q_i_d_q   <= q_i_d_d;
      q_mem_q   <= q_mem_d;
      q_paddr_q <= q_paddr_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign q_req_o   = q_req_q;
  assign q_write_o = q_write_q;
  assign q_i_d_o   = q_i_d_q;
  assign q_mem_o   = q_mem_q;
  assign q_paddr_o = q_paddr_q;

endmodule
